univ_shifter_pipe: RTL and testbench



---
 rtl/univ_shifter_pkg.sv | 42 ++++
 rtl/univ_shifter_pipe_shift_stage.sv | 68 ++++++
 rtl/univ_shifter_pipe.sv | 133 +++++++++++++
 tb/tb_univ_shifter_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shifter_pkg.sv
// ============================================================================
// Module   : univ_shifter_pkg
// Brief    : Mode codes, op-class enum and mode decode for univ_shifter_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shifter_pkg;

    localparam logic [2:0] MODE_ROL_A = 3'b100;
    localparam logic [2:0] MODE_ROL_B = 3'b110;
    localparam logic [2:0] MODE_ROR_A = 3'b101;
    localparam logic [2:0] MODE_ROR_B = 3'b111;
    localparam logic [2:0] MODE_LSH_A = 3'b000;
    localparam logic [2:0] MODE_LSH_B = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SAR   = 3'b011;

    typedef enum logic [2:0] {
        ROL = 3'd0,
        ROR = 3'd1,
        LSH = 3'd2,
        SHR = 3'd3,
        SAR = 3'd4
    } op_e;

    function automatic op_e decode_mode(input logic [2:0] mode);
        op_e op;
        op = LSH;
        case (mode)
            MODE_ROL_A, MODE_ROL_B: op = ROL;
            MODE_ROR_A, MODE_ROR_B: op = ROR;
            MODE_LSH_A, MODE_LSH_B: op = LSH;
            MODE_SHR:               op = SHR;
            MODE_SAR:               op = SAR;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/univ_shifter_pipe_shift_stage.sv
// ============================================================================
// Module   : shift_stage
// Brief    : One combinational log-shift step of AMT bits with carry select.
//            Carry ports exist only when UNIV_SHIFTER_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import univ_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  op_e              i_op,
    input  logic             i_sign,
`ifdef UNIV_SHIFTER_FLAGS_EN
    input  logic             i_carry,
    output logic             o_carry,
`endif
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_lsh;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_sar;

    assign w_rol = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
    assign w_ror = {i_data[AMT-1:0], i_data[WIDTH-1:AMT]};
    assign w_lsh = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
    assign w_shr = {{AMT{1'b0}}, i_data[WIDTH-1:AMT]};
    assign w_sar = {{AMT{i_sign}}, i_data[WIDTH-1:AMT]};

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                ROL:     o_data = w_rol;
                ROR:     o_data = w_ror;
                LSH:     o_data = w_lsh;
                SHR:     o_data = w_shr;
                SAR:     o_data = w_sar;
                default: o_data = i_data;
            endcase
        end
    end

`ifdef UNIV_SHIFTER_FLAGS_EN
    // Left-moving ops lose the top AMT bits, the last of which is bit WIDTH-AMT.
    always_comb begin
        o_carry = i_carry;
        if (i_en) begin
            if (i_op == ROL || i_op == LSH) begin
                o_carry = i_data[WIDTH-AMT];
            end else begin
                o_carry = i_data[AMT-1];
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/univ_shifter_pipe.sv
// ============================================================================
// Module   : univ_shifter_pipe
// Brief    : Pipelined universal shifter, one registered log-shift stage per
//            shift-amount bit, global-stall handshake. Optional flags via
//            UNIV_SHIFTER_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shifter_pipe
    import univ_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic             r_valid [SHW];
    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_shift [SHW];
    logic [2:0]       r_mode  [SHW];
    logic             r_sign  [SHW];

    logic             w_src_valid [SHW];
    logic [WIDTH-1:0] w_src_data  [SHW];
    logic [SHW-1:0]   w_src_shift [SHW];
    logic [2:0]       w_src_mode  [SHW];
    logic             w_src_sign  [SHW];
    op_e              w_src_op    [SHW];
    logic [WIDTH-1:0] w_stg_data  [SHW];

`ifdef UNIV_SHIFTER_FLAGS_EN
    logic             r_carry     [SHW];
    logic             w_src_carry [SHW];
    logic             w_stg_carry [SHW];
`endif

    logic w_adv;

    // Whole pipe moves together; only a blocked output result can stall it.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_src_valid[k] = in_valid & w_adv;
                assign w_src_data[k]  = in_data;
                assign w_src_shift[k] = in_shift;
                assign w_src_mode[k]  = in_mode;
                assign w_src_sign[k]  = in_data[WIDTH-1];
`ifdef UNIV_SHIFTER_FLAGS_EN
                assign w_src_carry[k] = 1'b0;
`endif
            end else begin : g_body
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_data[k]  = r_data[k-1];
                assign w_src_shift[k] = r_shift[k-1];
                assign w_src_mode[k]  = r_mode[k-1];
                assign w_src_sign[k]  = r_sign[k-1];
`ifdef UNIV_SHIFTER_FLAGS_EN
                assign w_src_carry[k] = r_carry[k-1];
`endif
            end

            assign w_src_op[k] = decode_mode(w_src_mode[k]);

            shift_stage #(
                .WIDTH (WIDTH),
                .AMT   (1 << k)
            ) u_shift_stage (
                .i_data  (w_src_data[k]),
                .i_en    (w_src_shift[k][k]),
                .i_op    (w_src_op[k]),
                .i_sign  (w_src_sign[k]),
`ifdef UNIV_SHIFTER_FLAGS_EN
                .i_carry (w_src_carry[k]),
                .o_carry (w_stg_carry[k]),
`endif
                .o_data  (w_stg_data[k])
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                    r_shift[k] <= '0;
                    r_mode[k]  <= '0;
                    r_sign[k]  <= 1'b0;
`ifdef UNIV_SHIFTER_FLAGS_EN
                    r_carry[k] <= 1'b0;
`endif
                end else if (w_adv) begin
                    r_valid[k] <= w_src_valid[k];
                    r_data[k]  <= w_stg_data[k];
                    r_shift[k] <= w_src_shift[k];
                    r_mode[k]  <= w_src_mode[k];
                    r_sign[k]  <= w_src_sign[k];
`ifdef UNIV_SHIFTER_FLAGS_EN
                    r_carry[k] <= w_stg_carry[k];
`endif
                end
            end
        end
    endgenerate

    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_data[SHW-1];

`ifdef UNIV_SHIFTER_FLAGS_EN
    assign out_carry = r_carry[SHW-1];
    assign out_zero  = ~|out_data;
`else
    assign out_carry = 1'b0;
    assign out_zero  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_univ_shifter_pipe.sv
// ============================================================================
// Module   : tb_univ_shifter_pipe
// Brief    : Self-checking bench for univ_shifter_pipe (WIDTH=16); honours
//            UNIV_SHIFTER_FLAGS_EN for the expected flag values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shifter_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
`ifdef UNIV_SHIFTER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    univ_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        c;
    } exp_t;

    exp_t        q[$];
    exp_t        p_exp;
    logic [15:0] p_data;
    logic [3:0]  p_shift;
    logic [2:0]  p_mode;
    logic        acc;
    int          cyc, acc_cyc, out_cyc, accepts, outputs;
    int          n_checks, n_errors;
    string       cur;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate via a doubled word, carry is the last bit past the edge.
    function automatic exp_t model(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m);
        exp_t        r;
        logic [31:0] dd;
        logic [15:0] t;
        int          si;
        si  = int'(s);
        dd  = {d, d};
        r.c = 1'b0;
        r.d = d;
        if (m[2] && m[0]) begin
            dd  = dd >> si;
            r.d = dd[15:0];
        end else if (m[2]) begin
            dd  = dd << si;
            r.d = dd[31:16];
        end else if (!m[0]) begin
            r.d = d << si;
        end else if (!m[1]) begin
            r.d = d >> si;
        end else begin
            r.d = $signed(d) >>> si;
        end
        if (si > 0) begin
            if (m[0]) t = d >> (si - 1);
            else      t = d >> (16 - si);
            r.c = t[0];
        end
        return r;
    endfunction

    task automatic set_op(input logic [15:0] d, input logic [3:0] s, input logic [2:0] m,
                          input logic [15:0] ed, input logic ec);
        p_data  = d;
        p_shift = s;
        p_mode  = m;
        p_exp.d = ed;
        p_exp.c = ec;
    endtask

    task automatic step(input logic v, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = p_data;
        in_shift  = p_shift;
        in_mode   = p_mode;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_val({cur, ".spurious"}, 1, 0);
            end else begin
                e = q.pop_front();
                check_val({cur, ".data"},  out_data,  e.d);
                check_val({cur, ".carry"}, out_carry, FLAGS ? e.c : 1'b0);
                check_val({cur, ".zero"},  out_zero,  FLAGS ? (e.d == 16'h0) : 1'b0);
            end
            out_cyc = cyc;
            outputs++;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            q.push_back(p_exp);
            accepts++;
            acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while (q.size() != 0 && g < budget) begin
            step(1'b0, 1'b1);
            g++;
        end
        if (q.size() != 0) begin
            check_val({cur, ".drain_timeout"}, q.size(), 0);
            q.delete();
        end
    endtask

    task automatic send(input string tag, input logic [15:0] d, input logic [3:0] s,
                        input logic [2:0] m, input logic [15:0] ed, input logic ec);
        int g;
        cur = tag;
        set_op(d, s, m, ed, ec);
        g   = 0;
        acc = 1'b0;
        while (!acc && g < 20) begin
            step(1'b1, 1'b1);
            g++;
        end
        if (!acc) check_val({tag, ".accept_timeout"}, 0, 1);
        drain(20);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nxt, sent, g;
        exp_t r;
        logic [15:0] rd;
        logic [3:0]  rs;
        logic [2:0]  rm;

        n_checks = 0; n_errors = 0; cyc = 0; accepts = 0; outputs = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
        out_ready = 1'b1;
        set_op(16'h0, 4'h0, 3'b000, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst.out_valid", out_valid, 0);
        check_val("rst.out_data",  out_data,  0);
        check_val("rst.out_carry", out_carry, 0);
        check_val("rst.out_zero",  out_zero,  FLAGS ? 1'b1 : 1'b0);
        check_val("rst.in_ready",  in_ready,  1);

        // Directed vectors, expected values worked by hand.
        send("lsh_8001_1", 16'h8001, 4'd1, 3'b000, 16'h0002, 1'b1);
        check_val("lsh_8001_1.latency", out_cyc - acc_cyc, SHW);
        send("sar_8000_4",   16'h8000, 4'd4,  3'b011, 16'hF800, 1'b0);
        send("shr_F000_12",  16'hF000, 4'd12, 3'b001, 16'h000F, 1'b0);
        send("ror_0001_1",   16'h0001, 4'd1,  3'b101, 16'h8000, 1'b1);
        send("rol_8001_4",   16'h8001, 4'd4,  3'b110, 16'h0018, 1'b0);
        send("lsh_0180_8",   16'h0180, 4'd8,  3'b010, 16'h8000, 1'b1);
        send("sar_7FFF_15",  16'h7FFF, 4'd15, 3'b011, 16'h0000, 1'b1);
        send("rol_1235_15",  16'h1235, 4'd15, 3'b100, 16'h891A, 1'b0);
        send("ror_8001_15",  16'h8001, 4'd15, 3'b111, 16'h0003, 1'b0);
        send("shr_8000_15",  16'h8000, 4'd15, 3'b001, 16'h0001, 1'b0);
        send("shr_4001_1",   16'h4001, 4'd1,  3'b001, 16'h2000, 1'b1);
        for (int m = 0; m < 8; m++) begin
            send($sformatf("zero_shift_m%0d", m), 16'hA5C3, 4'd0, 3'(m), 16'hA5C3, 1'b0);
        end

        // Backpressure: stalled output lets exactly SHW operands in.
        cur = "bp"; accepts = 0; outputs = 0; nxt = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(16'h1000 + 16'(nxt), 4'd0, 3'b000, 16'h1000 + 16'(nxt), 1'b0);
            step(1'b1, 1'b0);
            if (acc) nxt++;
        end
        @(negedge clk);
        #1;
        check_val("bp.accepted", accepts, SHW);
        check_val("bp.in_ready", in_ready, 0);
        check_val("bp.out_valid", out_valid, 1);
        check_val("bp.out_data_held", out_data, 16'h1000);
        g = 0;
        while ((nxt < 8 || q.size() != 0) && g < 60) begin
            set_op(16'h1000 + 16'(nxt), 4'd0, 3'b000, 16'h1000 + 16'(nxt), 1'b0);
            step(nxt < 8, 1'b1);
            if (acc) nxt++;
            g++;
        end
        check_val("bp.outputs", outputs, 8);
        check_val("bp.queue_empty", q.size(), 0);

        // Random stream with input and output gaps.
        cur = "rand"; outputs = 0; sent = 0; g = 0;
        rd = 16'($urandom); rs = 4'($urandom); rm = 3'($urandom);
        r  = model(rd, rs, rm);
        set_op(rd, rs, rm, r.d, r.c);
        while (sent < 1000 && g < 20000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            if (acc) begin
                sent++;
                rd = 16'($urandom); rs = 4'($urandom); rm = 3'($urandom);
                r  = model(rd, rs, rm);
                set_op(rd, rs, rm, r.d, r.c);
            end
            g++;
        end
        check_val("rand.sent", sent, 1000);
        drain(100);
        check_val("rand.outputs", outputs, 1000);

        // Reset with three operations in flight.
        cur = "flush";
        for (int i = 0; i < 3; i++) begin
            set_op(16'h00F0 + 16'(i), 4'd1, 3'b000, 16'h0, 1'b0);
            step(1'b1, 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        #1;
        check_val("flush.out_valid", out_valid, 0);
        check_val("flush.in_ready",  in_ready,  1);
        outputs = 0;
        repeat (10) step(1'b0, 1'b1);
        check_val("flush.no_outputs", outputs, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
